// File: rtl/sram_arbiter_2p.sv
// Two-port round-robin arbiter sharing one 32-bit SRAM controller.
// One owner at a time: grant, single-cycle strobe, wait for ACK (watchdog-bounded), complete.
module sram_arbiter_2p #(
   parameter int ADDR_W  = 18,
   parameter int TIMEOUT = 64
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_REQ0,
   input  logic              i_REQ1,
   input  logic              i_WE0,
   input  logic              i_WE1,
   input  logic [ADDR_W-1:0] i_ADDR0,
   input  logic [ADDR_W-1:0] i_ADDR1,
   input  logic [31:0]       i_WDATA0,
   input  logic [31:0]       i_WDATA1,
   input  logic [3:0]        i_BMASK0,
   input  logic [3:0]        i_BMASK1,
   output logic [31:0]       o_RDATA0,
   output logic [31:0]       o_RDATA1,
   output logic              o_ACK0,
   output logic              o_ACK1,
   output logic              o_ERR0,
   output logic              o_ERR1,
   output logic [1:0]        o_GNT,
   output logic [ADDR_W-1:0] o_ADDR,
   output logic [31:0]       o_WDATA,
   output logic [3:0]        o_BMASK,
   output logic              o_WREN,
   output logic              o_RDEN,
   input  logic [31:0]       i_RDATA,
   input  logic              i_ACK
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic WDOG_EN = (TIMEOUT > 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                last_q, last_d;
   logic                owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [3:0]          bmask_q, bmask_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          gnt_q, gnt_d;
   logic                wren_q, wren_d;
   logic                rden_q, rden_d;
   logic                ack0_q, ack0_d;
   logic                ack1_q, ack1_d;
   logic                err0_q, err0_d;
   logic                err1_q, err1_d;
   logic [31:0]         rdata0_q, rdata0_d;
   logic [31:0]         rdata1_q, rdata1_d;
   logic                pick_port;

   // State and output registers; last-grant resets to 1 so port 0 wins first contention.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         owner_q  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= 32'h0000_0000;
         bmask_q  <= 4'h0;
         cnt_q    <= '0;
         gnt_q    <= 2'b00;
         wren_q   <= 1'b0;
         rden_q   <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
         rdata0_q <= 32'h0000_0000;
         rdata1_q <= 32'h0000_0000;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         bmask_q  <= bmask_d;
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         wren_q   <= wren_d;
         rden_q   <= rden_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         err0_q   <= err0_d;
         err1_q   <= err1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   // Next-state and registered-output decode; pulses default low every cycle.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      owner_d   = owner_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      bmask_d   = bmask_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      wren_d    = 1'b0;
      rden_d    = 1'b0;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      err0_d    = 1'b0;
      err1_d    = 1'b0;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      pick_port = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_REQ0 && i_REQ1) begin
               pick_port = ~last_q;
            end else begin
               pick_port = i_REQ1;
            end
            if (i_REQ0 || i_REQ1) begin
               owner_d = pick_port;
               last_d  = pick_port;
               we_d    = pick_port ? i_WE1    : i_WE0;
               addr_d  = pick_port ? i_ADDR1  : i_ADDR0;
               wdata_d = pick_port ? i_WDATA1 : i_WDATA0;
               bmask_d = pick_port ? i_BMASK1 : i_BMASK0;
               gnt_d   = pick_port ? 2'b10 : 2'b01;
               cnt_d   = '0;
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end

         ISSUE: begin
            // The controller re-triggers on a held strobe, so this is the only cycle that raises it.
            wren_d  = we_q;
            rden_d  = ~we_q;
            state_d = WAIT;
         end

         WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (i_ACK) begin
               state_d = DONE;
               if (owner_q) begin
                  rdata1_d = i_RDATA;
                  ack1_d   = 1'b1;
               end else begin
                  rdata0_d = i_RDATA;
                  ack0_d   = 1'b1;
               end
            end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
               state_d = DONE;
               if (owner_q) begin
                  rdata1_d = 32'h0000_0000;
                  ack1_d   = 1'b1;
                  err1_d   = 1'b1;
               end else begin
                  rdata0_d = 32'h0000_0000;
                  ack0_d   = 1'b1;
                  err0_d   = 1'b1;
               end
            end else begin
               state_d = WAIT;
            end
         end

         DONE: begin
            cnt_d   = '0;
            gnt_d   = 2'b00;
            state_d = IDLE;
         end

         default: begin
            gnt_d   = 2'b00;
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign o_GNT    = gnt_q;
   assign o_ADDR   = addr_q;
   assign o_WDATA  = wdata_q;
   assign o_BMASK  = bmask_q;
   assign o_WREN   = wren_q;
   assign o_RDEN   = rden_q;
   assign o_ACK0   = ack0_q;
   assign o_ACK1   = ack1_q;
   assign o_ERR0   = err0_q;
   assign o_ERR1   = err1_q;
   assign o_RDATA0 = rdata0_q;
   assign o_RDATA1 = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// Directed bench for sram_arbiter_2p with a behavioural SRAM controller model
// (write ACK 2 cycles after strobe, read ACK 6 cycles after strobe).
module tb_sram_arbiter_2p;

   localparam int ADDR_W = 18;

   logic              i_clk = 1'b0;
   logic              i_reset;
   logic              i_REQ0, i_REQ1, i_WE0, i_WE1;
   logic [ADDR_W-1:0] i_ADDR0, i_ADDR1;
   logic [31:0]       i_WDATA0, i_WDATA1;
   logic [3:0]        i_BMASK0, i_BMASK1;
   logic [31:0]       o_RDATA0, o_RDATA1;
   logic              o_ACK0, o_ACK1, o_ERR0, o_ERR1;
   logic [1:0]        o_GNT;
   logic [ADDR_W-1:0] o_ADDR;
   logic [31:0]       o_WDATA;
   logic [3:0]        o_BMASK;
   logic              o_WREN, o_RDEN;
   logic [31:0]       i_RDATA = 32'h0000_0000;
   logic              i_ACK;
   logic              ctl_ack = 1'b0;
   logic              spur_ack = 1'b0;
   logic              ctl_en = 1'b1;
   int                ctl_cnt = 0;
   int                errors = 0;
   int                checks = 0;

   assign i_ACK = ctl_ack | spur_ack;

   always #5 i_clk = ~i_clk;

   sram_arbiter_2p #(.ADDR_W(ADDR_W), .TIMEOUT(64)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_REQ0(i_REQ0), .i_REQ1(i_REQ1), .i_WE0(i_WE0), .i_WE1(i_WE1),
      .i_ADDR0(i_ADDR0), .i_ADDR1(i_ADDR1), .i_WDATA0(i_WDATA0), .i_WDATA1(i_WDATA1),
      .i_BMASK0(i_BMASK0), .i_BMASK1(i_BMASK1), .o_RDATA0(o_RDATA0), .o_RDATA1(o_RDATA1),
      .o_ACK0(o_ACK0), .o_ACK1(o_ACK1), .o_ERR0(o_ERR0), .o_ERR1(o_ERR1), .o_GNT(o_GNT),
      .o_ADDR(o_ADDR), .o_WDATA(o_WDATA), .o_BMASK(o_BMASK), .o_WREN(o_WREN), .o_RDEN(o_RDEN),
      .i_RDATA(i_RDATA), .i_ACK(i_ACK)
   );

   function automatic logic [31:0] mem_model(input logic [ADDR_W-1:0] a);
      return 32'hDEAD_BEFF ^ {14'd0, a};
   endfunction

   // Controller model: sees a strobe, then raises ACK for one cycle 2 (write) or 6 (read) cycles later.
   always @(negedge i_clk) begin
      ctl_ack = 1'b0;
      if (ctl_cnt == 1) begin
         ctl_ack = 1'b1;
         i_RDATA = mem_model(o_ADDR);
      end
      if (ctl_cnt > 0) ctl_cnt = ctl_cnt - 1;
      if (ctl_en && (o_RDEN || o_WREN)) ctl_cnt = o_WREN ? 2 : 6;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected finish before 2ms");
      $fatal(1);
   end

   task automatic test_reset();
      @(negedge i_clk);
      i_reset = 1'b1;
      repeat (2) @(negedge i_clk);
      checks++;
      if (o_GNT !== 2'b00) begin
         errors++; $display("FAIL reset_gnt: got %b expected 00", o_GNT);
      end
      checks++;
      if ({o_ACK0, o_ACK1, o_ERR0, o_ERR1, o_WREN, o_RDEN} !== 6'b000000) begin
         errors++; $display("FAIL reset_pulses: got %b expected 000000",
                            {o_ACK0, o_ACK1, o_ERR0, o_ERR1, o_WREN, o_RDEN});
      end
      checks++;
      if ({o_ADDR, o_WDATA, o_BMASK} !== {ADDR_W'(0), 32'h0, 4'h0}) begin
         errors++; $display("FAIL reset_cmd: got addr=%h wdata=%h bmask=%h expected zeros",
                            o_ADDR, o_WDATA, o_BMASK);
      end
      checks++;
      if ({o_RDATA0, o_RDATA1} !== 64'h0) begin
         errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", o_RDATA0, o_RDATA1);
      end
      i_reset = 1'b0;
   endtask

   task automatic test_single_read();
      int ack_at, rden_cnt, rden_at;
      bit wren_seen, ack1_seen, gnt_bad;
      ack_at = -1; rden_cnt = 0; rden_at = -1;
      wren_seen = 1'b0; ack1_seen = 1'b0; gnt_bad = 1'b0;
      @(negedge i_clk);
      i_REQ0 = 1'b1; i_WE0 = 1'b0; i_ADDR0 = 18'h00010; i_BMASK0 = 4'hF;
      for (int k = 1; k <= 20; k++) begin
         @(negedge i_clk);
         if (o_RDEN) begin rden_cnt++; rden_at = k; end
         if (o_WREN) wren_seen = 1'b1;
         if (o_ACK1) ack1_seen = 1'b1;
         if (k <= 8 && o_GNT !== 2'b01) gnt_bad = 1'b1;
         if (o_ACK0 && ack_at < 0) begin
            ack_at = k;
            i_REQ0 = 1'b0;
            checks++;
            if (o_RDATA0 !== 32'hDEAD_BEEF) begin
               errors++; $display("FAIL rd_data: got %h expected deadbeef", o_RDATA0);
            end
            checks++;
            if (o_ERR0 !== 1'b0) begin
               errors++; $display("FAIL rd_err: got %b expected 0", o_ERR0);
            end
         end
      end
      checks++;
      if (ack_at != 9) begin
         errors++; $display("FAIL rd_ack_cycle: got %0d expected 9", ack_at);
      end
      checks++;
      if (rden_cnt != 1 || rden_at != 2) begin
         errors++; $display("FAIL rd_strobe: got count=%0d at=%0d expected count=1 at=2", rden_cnt, rden_at);
      end
      checks++;
      if (wren_seen || ack1_seen || gnt_bad) begin
         errors++; $display("FAIL rd_side: got wren=%b ack1=%b gnt_bad=%b expected 0 0 0",
                            wren_seen, ack1_seen, gnt_bad);
      end
      checks++;
      if (o_RDATA0 !== 32'hDEAD_BEEF || o_GNT !== 2'b00) begin
         errors++; $display("FAIL rd_hold: got rdata=%h gnt=%b expected deadbeef 00", o_RDATA0, o_GNT);
      end
   endtask

   task automatic test_write_p1();
      int ack_at, wren_cnt;
      bit rden_seen, cmd_ok;
      ack_at = -1; wren_cnt = 0; rden_seen = 1'b0; cmd_ok = 1'b0;
      @(negedge i_clk);
      i_REQ1 = 1'b1; i_WE1 = 1'b1; i_ADDR1 = 18'h3FFFF; i_WDATA1 = 32'h1234_5678; i_BMASK1 = 4'hF;
      for (int k = 1; k <= 12; k++) begin
         @(negedge i_clk);
         if (o_RDEN) rden_seen = 1'b1;
         if (o_WREN) begin
            wren_cnt++;
            cmd_ok = (k == 2) && (o_ADDR === 18'h3FFFF) && (o_WDATA === 32'h1234_5678) && (o_BMASK === 4'hF);
         end
         if (o_ACK1 && ack_at < 0) begin ack_at = k; i_REQ1 = 1'b0; end
      end
      checks++;
      if (ack_at != 5) begin
         errors++; $display("FAIL wr_ack_cycle: got %0d expected 5", ack_at);
      end
      checks++;
      if (wren_cnt != 1 || !cmd_ok) begin
         errors++; $display("FAIL wr_strobe: got count=%0d cmd_ok=%b expected 1 1", wren_cnt, cmd_ok);
      end
      checks++;
      if (rden_seen) begin
         errors++; $display("FAIL wr_rden: got 1 expected 0");
      end
   endtask

   task automatic test_back_to_back();
      int n0, n1, rd_bad;
      int order[$];
      bit two_acks, ord_bad;
      logic [1:0] prev_gnt;
      n0 = 0; n1 = 0; rd_bad = 0; two_acks = 1'b0; ord_bad = 1'b0; prev_gnt = 2'b00;
      @(negedge i_clk);
      i_reset = 1'b1;
      @(negedge i_clk);
      i_reset = 1'b0;
      i_WE0 = 1'b0; i_WE1 = 1'b0; i_ADDR0 = 18'h00100; i_ADDR1 = 18'h00200;
      i_REQ0 = 1'b1; i_REQ1 = 1'b1;
      for (int c = 0; c < 400 && (n0 < 4 || n1 < 4); c++) begin
         @(negedge i_clk);
         if (o_ACK0 && o_ACK1) two_acks = 1'b1;
         if (prev_gnt == 2'b00 && o_GNT != 2'b00) order.push_back(o_GNT == 2'b10 ? 1 : 0);
         prev_gnt = o_GNT;
         if (o_ACK0) begin
            if (o_RDATA0 !== mem_model(ADDR_W'(256 + n0))) rd_bad++;
            n0++; i_REQ0 = 1'b0; i_ADDR0 = ADDR_W'(256 + n0);
         end else if (!i_REQ0 && n0 < 4) begin
            i_REQ0 = 1'b1;
         end
         if (o_ACK1) begin
            if (o_RDATA1 !== mem_model(ADDR_W'(512 + n1))) rd_bad++;
            n1++; i_REQ1 = 1'b0; i_ADDR1 = ADDR_W'(512 + n1);
         end else if (!i_REQ1 && n1 < 4) begin
            i_REQ1 = 1'b1;
         end
      end
      if (order.size() != 8) ord_bad = 1'b1;
      for (int i = 0; i < order.size(); i++) if (order[i] != (i % 2)) ord_bad = 1'b1;
      checks++;
      if (n0 != 4 || n1 != 4) begin
         errors++; $display("FAIL b2b_count: got %0d/%0d expected 4/4", n0, n1);
      end
      checks++;
      if (ord_bad) begin
         errors++; $display("FAIL b2b_order: got %p expected alternating 0,1 x4", order);
      end
      checks++;
      if (two_acks) begin
         errors++; $display("FAIL b2b_dual_ack: got 1 expected 0");
      end
      checks++;
      if (rd_bad != 0) begin
         errors++; $display("FAIL b2b_rdata: got %0d bad reads expected 0", rd_bad);
      end
   endtask

   task automatic test_timeout();
      int ack_at, ack2_at;
      ack_at = -1; ack2_at = -1;
      @(negedge i_clk);
      ctl_en = 1'b0;
      @(negedge i_clk);
      i_REQ0 = 1'b1; i_WE0 = 1'b0; i_ADDR0 = 18'h00020;
      for (int k = 1; k <= 80; k++) begin
         @(negedge i_clk);
         if (o_ACK0 && ack_at < 0) begin
            ack_at = k;
            i_REQ0 = 1'b0;
            checks++;
            if (o_ERR0 !== 1'b1 || o_RDATA0 !== 32'h0) begin
               errors++; $display("FAIL to_abort: got err=%b rdata=%h expected 1 00000000", o_ERR0, o_RDATA0);
            end
         end
      end
      checks++;
      if (ack_at != 66) begin
         errors++; $display("FAIL to_cycle: got %0d expected 66", ack_at);
      end
      ctl_en = 1'b1;
      @(negedge i_clk);
      i_REQ0 = 1'b1; i_ADDR0 = 18'h00030;
      for (int k = 1; k <= 15; k++) begin
         @(negedge i_clk);
         if (o_ACK0 && ack2_at < 0) begin
            ack2_at = k;
            i_REQ0 = 1'b0;
            checks++;
            if (o_ERR0 !== 1'b0 || o_RDATA0 !== mem_model(18'h00030)) begin
               errors++; $display("FAIL to_recover: got err=%b rdata=%h expected 0 %h",
                                  o_ERR0, o_RDATA0, mem_model(18'h00030));
            end
         end
      end
      checks++;
      if (ack2_at != 9) begin
         errors++; $display("FAIL to_recover_cycle: got %0d expected 9", ack2_at);
      end
   endtask

   task automatic test_reset_mid();
      bit stray;
      int n;
      stray = 1'b0; n = 0;
      @(negedge i_clk);
      i_REQ0 = 1'b1; i_WE0 = 1'b0; i_ADDR0 = 18'h00040;
      repeat (4) @(negedge i_clk);
      i_reset = 1'b1; i_REQ0 = 1'b0;
      @(negedge i_clk);
      checks++;
      if ({o_GNT, o_ACK0, o_ACK1, o_ERR0, o_ERR1, o_WREN, o_RDEN} !== 8'h00 || o_RDATA0 !== 32'h0
          || o_ADDR !== 18'h0) begin
         errors++; $display("FAIL rst_mid_out: got gnt=%b ack0=%b rden=%b rdata0=%h addr=%h expected zeros",
                            o_GNT, o_ACK0, o_RDEN, o_RDATA0, o_ADDR);
      end
      i_reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge i_clk);
         if (o_ACK0 || o_ACK1 || o_GNT != 2'b00) stray = 1'b1;
      end
      checks++;
      if (stray) begin
         errors++; $display("FAIL rst_mid_late_ack: got activity expected none");
      end
      i_REQ0 = 1'b1; i_REQ1 = 1'b1; i_WE1 = 1'b0; i_ADDR0 = 18'h00041; i_ADDR1 = 18'h00042;
      @(negedge i_clk);
      checks++;
      if (o_GNT !== 2'b01) begin
         errors++; $display("FAIL rst_mid_first_gnt: got %b expected 01", o_GNT);
      end
      for (int c = 0; c < 60 && n < 2; c++) begin
         @(negedge i_clk);
         if (o_ACK0) begin i_REQ0 = 1'b0; n++; end
         if (o_ACK1) begin i_REQ1 = 1'b0; n++; end
      end
      checks++;
      if (n != 2) begin
         errors++; $display("FAIL rst_mid_drain: got %0d acks expected 2", n);
      end
   endtask

   task automatic test_spurious();
      bit stray, addr_bad;
      int ack_at;
      stray = 1'b0; addr_bad = 1'b0; ack_at = -1;
      @(negedge i_clk);
      spur_ack = 1'b1;
      @(negedge i_clk);
      spur_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         if (o_ACK0 || o_ACK1 || o_GNT != 2'b00 || o_WREN || o_RDEN) stray = 1'b1;
      end
      checks++;
      if (stray) begin
         errors++; $display("FAIL spur_idle: got activity expected none");
      end
      i_REQ0 = 1'b1; i_WE0 = 1'b0; i_ADDR0 = 18'h00055;
      for (int k = 1; k <= 15; k++) begin
         @(negedge i_clk);
         if (k == 3) i_ADDR0 = 18'h000AA;
         if (k <= 9 && o_ADDR !== 18'h00055) addr_bad = 1'b1;
         if (o_ACK0 && ack_at < 0) begin
            ack_at = k;
            i_REQ0 = 1'b0;
            checks++;
            if (o_RDATA0 !== mem_model(18'h00055)) begin
               errors++; $display("FAIL spur_rdata: got %h expected %h", o_RDATA0, mem_model(18'h00055));
            end
         end
      end
      checks++;
      if (addr_bad || ack_at != 9) begin
         errors++; $display("FAIL spur_latch: got addr_bad=%b ack_at=%0d expected 0 9", addr_bad, ack_at);
      end
   endtask

   initial begin
      i_reset = 1'b0; i_REQ0 = 1'b0; i_REQ1 = 1'b0; i_WE0 = 1'b0; i_WE1 = 1'b0;
      i_ADDR0 = '0; i_ADDR1 = '0; i_WDATA0 = 32'h0; i_WDATA1 = 32'h0;
      i_BMASK0 = 4'h0; i_BMASK1 = 4'h0;
      test_reset();
      test_single_read();
      test_write_p1();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      test_spurious();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_arbiter_2p.md
Name: sram_arbiter_2p

Overview:
- Two-port round-robin arbiter sharing the single 32-bit SRAM controller between two requesters, e.g. I-cache and D-cache refill/writeback ports.
- Grants one requester at a time and latches its command.
- Issues a single-cycle WREN/RDEN strobe to the controller, waits for its ACK, then returns read data and a one-cycle ACK to the owner.
- A watchdog aborts transactions whose downstream ACK never arrives.

Parameters:
- ADDR_W, 18, SRAM word address width (matches controller address).
- TIMEOUT, 64, max WAIT cycles before abort; 0 disables the watchdog.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_REQ0 / i_REQ1  in  1  request, level, held until the matching o_ACKn
- i_WE0 / i_WE1  in  1  1 = write, 0 = read
- i_ADDR0 / i_ADDR1  in  ADDR_W  address
- i_WDATA0 / i_WDATA1  in  32  write data
- i_BMASK0 / i_BMASK1  in  4  byte enables
- o_RDATA0 / o_RDATA1  out  32  read data, valid while o_ACKn=1
- o_ACK0 / o_ACK1  out  1  one-cycle completion pulse
- o_ERR0 / o_ERR1  out  1  one-cycle pulse with o_ACKn on timeout abort
- o_GNT  out  2  one-hot current owner, 00 when idle
- o_ADDR  out  ADDR_W  to controller i_ADDR
- o_WDATA  out  32  to controller
- o_BMASK  out  4  to controller
- o_WREN  out  1  to controller
- o_RDEN  out  1  to controller
- i_RDATA  in  32  from controller o_RDATA
- i_ACK  in  1  from controller o_ACK

Behaviour:
- Reset (synchronous, i_reset=1 at posedge):
  - state=IDLE, o_GNT=00, all o_ACKn/o_ERRn/o_WREN/o_RDEN=0.
  - o_ADDR/o_WDATA/o_BMASK/o_RDATAn=0, watchdog counter=0.
  - last-grant pointer=1, so port 0 wins the first contention.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the port != last-grant.
  - On grant: latch WE/ADDR/WDATA/BMASK into the command regs, set o_GNT, update last-grant, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - o_WREN=WE, o_RDEN=~WE; never both 1.
  - Go to WAIT.
  - o_ADDR/o_WDATA/o_BMASK are driven from the command regs from ISSUE through DONE.
- WAIT:
  - o_WREN=o_RDEN=0. The controller restarts if its strobe is still high in its ack state, so the strobe must be a single-cycle pulse.
  - Counter increments each cycle.
  - i_ACK=1: capture i_RDATA into the owner's o_RDATAn register, go to DONE.
  - TIMEOUT>0 and counter==TIMEOUT-1 with no ACK: set o_RDATAn=0, flag error, go to DONE.
- DONE (1 cycle):
  - Owner's o_ACKn=1; o_ERRn=1 if aborted.
  - Clear the counter and o_GNT, go to IDLE.
  - o_RDATAn holds its value until the next completion on that port.
- Latency:
  - Grant cycle to o_ACKn = 3 + controller latency (cycles strobe→i_ACK).
  - Controller write: i_ACK 2 cycles after strobe, so o_ACK 5 cycles after the grant cycle.
  - Controller read: i_ACK 6 cycles after strobe, so o_ACK 9 cycles after the grant cycle.
- Requester rule: drop i_REQn on the edge after o_ACKn. If i_REQn is still high in the following IDLE cycle, it is a new request.
  - Back-to-back from both ports therefore alternates 0,1,0,1.
- i_ACK outside WAIT is ignored. A late ACK after timeout is not tracked; the system is considered faulty after any o_ERR.
- Requests arriving in ISSUE/WAIT/DONE are not sampled until IDLE. Requester inputs may change after grant without effect.
- Reset mid-transaction: all state drops to reset values next cycle; no o_ACK is issued for the abandoned transaction.
- No combinational path from i_REQn to any output; all outputs are registered or decoded from state/command regs.

Test Plan:
- Single read port 0, ADDR=0x00010, controller model returns 0xDEADBEEF with i_ACK 6 cycles after o_RDEN → one o_RDEN pulse, o_GNT=01 through ISSUE..WAIT, o_ACK0 one cycle with o_RDATA0=0xDEADBEEF, o_ERR0=0, o_ACK1 never.
- Write port 1, ADDR=0x3FFFF, WDATA=0x12345678, BMASK=0xF → o_WREN one cycle with o_ADDR=0x3FFFF, o_WDATA=0x12345678, o_BMASK=0xF, o_RDEN=0 throughout, o_ACK1 5 cycles after the grant cycle.
- Both ports request continuously after reset, each with 4 transactions → grant order 0,1,0,1,0,1,0,1; never two o_ACKs in the same cycle; each o_RDATAn matches its own address.
- Controller never acks, TIMEOUT=64 → o_ACK0=o_ERR0=1 with o_RDATA0=0 exactly 64 WAIT cycles after ISSUE; next request serviced normally.
- i_reset asserted during WAIT of a port 0 read → next cycle o_GNT=00, all outputs 0, no o_ACK0; a later i_ACK is ignored; the first post-reset contention grants port 0.
- Spurious i_ACK in IDLE, and port 0 changing i_ADDR0 during WAIT → no o_ACK, no state change; o_ADDR keeps the latched address.
